axis_crc32_mpeg2_checker: RTL
=============================

Name: axis_crc32_mpeg2_checker

Overview:
Receive-side companion of the CRC-32/MPEG-2 stream generator. Consumes fixed-length frames from an AXI-Stream slave port: FRAME_LEN payload words followed by a 32-bit CRC trailer. Forwards the payload unchanged through a registered AXI-Stream master port and strips the trailer. Reports a per-frame pass/fail status and keeps error and frame statistics.

Parameters:
AXI_DATA_WIDTH, 32, tdata width; legal values 8, 16, 32; CRC_WORDS = 32/AXI_DATA_WIDTH trailer words
FRAME_LEN, 16, payload words per frame; minimum 1
CNT_WIDTH, 16, width of the frame and error counters

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
s_axis_tdata  input  AXI_DATA_WIDTH  input payload/trailer word
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
m_axis_tdata  output  AXI_DATA_WIDTH  forwarded payload word
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
frame_done  output  1  one-cycle pulse per completed frame
crc_ok  output  1  result of the last completed frame; held until the next frame_done
frame_cnt  output  CNT_WIDTH  completed frames, wraps
err_cnt  output  CNT_WIDTH  failed frames, saturates at all-ones

Behaviour:
- Interface (already decided): one clock, aclk. Reset aresetn is synchronous and active-low.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, frame_done=0, crc_ok=0, frame_cnt=0, err_cnt=0, state=PAYLOAD, word counter=0, crc register=0xFFFFFFFF. s_axis_tready=1 after reset, since the output register is empty.
- Reset mid-frame discards the partial frame. The next accepted word is treated as payload word 0.
- CRC-32/MPEG-2: polynomial 0x04C11DB7, init 0xFFFFFFFF, no input or output reflection, no final XOR.
- Each word is processed MSB byte first and MSB bit first. The whole word is folded in a single cycle.
- The CRC covers payload and trailer words. A frame passes when the register equals 0x00000000 after the last trailer word (residue check).
- A word is accepted when s_axis_tvalid && s_axis_tready.
- State PAYLOAD:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (single output register, full throughput).
  - An accepted word loads m_axis_tdata, sets m_axis_tvalid, updates the CRC and increments the word counter.
  - After word FRAME_LEN-1 is accepted, go to TRAILER and clear the counter.
- State TRAILER:
  - s_axis_tready = 1; the trailer never waits on the master side.
  - An accepted word updates the CRC only and is not forwarded.
  - After word CRC_WORDS-1 is accepted, go to PAYLOAD and return the CRC register to 0xFFFFFFFF in that same cycle.
- Output register: m_axis_tvalid clears on m_axis_tready when no new payload word is accepted in the same cycle. tdata and tvalid stay stable while tvalid && !tready.
- Status (registered; appears one cycle after the final trailer handshake):
  - frame_done=1 for exactly one cycle.
  - crc_ok=(next CRC==0).
  - frame_cnt+1, wrapping.
  - err_cnt+1 on failure; no increment once err_cnt is all-ones.
- Back-to-back frames: payload word 0 of frame N+1 may be accepted in the cycle immediately after the last trailer word of frame N. No bubble is required.
- Latency: payload in to m_axis_tvalid is 1 cycle.
- Status is independent of m_axis_tready. A stalled master side delays frame_done only through input backpressure on payload words.

Test Plan:
- AXI_DATA_WIDTH=8, FRAME_LEN=9: send 0x31..0x39 then trailer 0x03,0x76,0xE6,0xE7, m_axis_tready=1, tvalid continuous -> m_axis emits 0x31..0x39 one cycle delayed; frame_done pulse 1 cycle after 0xE7 accepted; crc_ok=1; frame_cnt=1; err_cnt=0.
- Same frame with trailer last byte 0xE6 -> crc_ok=0, err_cnt=1. A following correct frame -> crc_ok=1, err_cnt stays 1, frame_cnt=2.
- AXI_DATA_WIDTH=32, FRAME_LEN=2: payload 0x31323334, 0x35363738, trailer = CRC-32/MPEG-2 of those 8 bytes computed by the reference model -> crc_ok=1. Three frames back-to-back with no idle cycles -> three frame_done pulses, 2 words apart in payload plus 1 trailer cycle (3-cycle spacing).
- Random m_axis_tready (50%) and s_axis_tvalid gaps over 100 frames -> payload sequence identical and in order, no drop or duplication, tdata stable while stalled, s_axis_tready=1 in every trailer cycle, crc_ok matches the model every frame.
- Assert aresetn=0 for one cycle after 5 payload words of a FRAME_LEN=9 frame, then send a full correct frame -> all outputs at reset values, and the new frame passes with frame_cnt=1.
- CNT_WIDTH=4, 17 bad frames -> err_cnt saturates at 15 and frame_cnt wraps to 1.

Source files
------------

// File: rtl/axis_crc32_mpeg2_checker.sv
// AXI-Stream CRC-32/MPEG-2 frame checker: forwards FRAME_LEN payload words,
// strips the CRC trailer and reports a residue-based pass/fail per frame.
module axis_crc32_mpeg2_checker #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int FRAME_LEN      = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      frame_done,
    output logic                      crc_ok,
    output logic [CNT_WIDTH-1:0]      frame_cnt,
    output logic [CNT_WIDTH-1:0]      err_cnt
);

    localparam int CRC_WORDS = 32 / AXI_DATA_WIDTH;
    localparam int CNT_MAX   = (FRAME_LEN > CRC_WORDS) ? FRAME_LEN : CRC_WORDS;
    localparam int WC_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [31:0] POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic {PAYLOAD, TRAILER} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [31:0]       crc_q, crc_d, crc_calc;
    logic              accept;
    logic              frame_last;

    // Whole word folded MSB first, one bit per loop step.
    function automatic logic [31:0] crc_fold(input logic [31:0] crc_in,
                                             input logic [AXI_DATA_WIDTH-1:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = AXI_DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return c;
    endfunction

    // The trailer is never forwarded, so it must not wait on the master side.
    assign s_axis_tready = (state_q == TRAILER) ? 1'b1 : (!m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign crc_calc      = crc_fold(crc_q, s_axis_tdata);

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        crc_d      = crc_q;
        frame_last = 1'b0;
        if (accept) begin
            crc_d = crc_calc;
            case (state_q)
                PAYLOAD: begin
                    if (wcnt_q == WC_W'(FRAME_LEN - 1)) begin
                        state_d = TRAILER;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                TRAILER: begin
                    if (wcnt_q == WC_W'(CRC_WORDS - 1)) begin
                        state_d    = PAYLOAD;
                        wcnt_d     = '0;
                        crc_d      = CRC_INIT;
                        frame_last = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                default: state_d = PAYLOAD;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= PAYLOAD;
            wcnt_q        <= '0;
            crc_q         <= CRC_INIT;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            frame_done    <= 1'b0;
            crc_ok        <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            crc_q   <= crc_d;
            if (accept && state_q == PAYLOAD) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            frame_done <= frame_last;
            if (frame_last) begin
                crc_ok    <= (crc_calc == 32'h0);
                frame_cnt <= frame_cnt + 1'b1;
                if (crc_calc != 32'h0 && err_cnt != {CNT_WIDTH{1'b1}})
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
